aes_selftest_seq: RTL and testbench

AES_SELFTEST_SEQ -- requirements
Module: aes_selftest_seq

---
 rtl/aes_pkg.sv | 43 ++++
 rtl/aes_selftest_seq_if.sv | 22 ++
 rtl/aes_seg_display.sv | 56 +++++
 rtl/aes_selftest_seq.sv | 123 ++++++++++++
 tb/tb_aes_selftest_seq.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// Shared constants and types for the AES known-answer self-test sequencer:
// key-size encoding, test vectors, seven-segment table and FSM states.
package aes_pkg;

    typedef enum logic [1:0] {
        KEY_128 = 2'd0,
        KEY_192 = 2'd1,
        KEY_256 = 2'd2
    } key_sel_e;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        CHECK,
        DONE
    } state_e;

    localparam logic [127:0] PLAINTEXT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CIPHER_128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CIPHER_192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] CIPHER_256 = 128'h8ea2b7ca516745bfeafc49904b496089;

    // Active-low segments {g,f,e,d,c,b,a}; entry n encodes decimal digit n.
    localparam logic [9:0][6:0] SEG_TABLE = {
        7'b0010000, 7'b0000000, 7'b1111000, 7'b0000010, 7'b0010010,
        7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
    };
    localparam logic [6:0] SEG_BLANK = '1;

    function automatic logic [127:0] cipher_for(input logic [1:0] key_sel);
        case (key_sel)
            KEY_128: return CIPHER_128;
            KEY_192: return CIPHER_192;
            default: return CIPHER_256;
        endcase
    endfunction

    function automatic logic [6:0] seg_encode(input logic [3:0] digit);
        return (digit <= 4'd9) ? SEG_TABLE[digit] : SEG_BLANK;
    endfunction

endpackage

// File: rtl/aes_selftest_seq_if.sv
// Request/response channel between the self-test sequencer and the AES engine.
interface aes_selftest_seq_if;
    import aes_pkg::*;

    logic         core_start;
    key_sel_e     core_key_sel;
    logic         core_decrypt;
    logic [127:0] core_block;
    logic         core_done;
    logic [127:0] core_result;

    modport master (
        output core_start, core_key_sel, core_decrypt, core_block,
        input  core_done, core_result
    );

    modport slave (
        input  core_start, core_key_sel, core_decrypt, core_block,
        output core_done, core_result
    );

endinterface

// File: rtl/aes_seg_display.sv
// Registered decimal display: digits 0..2 show a byte, digit 3 a test index,
// remaining digits blank.
module aes_seg_display
    import aes_pkg::*;
#(
    parameter int NUM_DIGITS = 6
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load,
    input  logic [7:0]              value,
    input  logic [2:0]              index,
    output logic [7*NUM_DIGITS-1:0] hex
);

    logic [7:0] value_q;

    // Double-dabble: three BCD nibbles above the 8-bit binary operand.
    function automatic logic [11:0] to_bcd(input logic [7:0] bin);
        logic [19:0] sh;
        sh = {12'd0, bin};
        for (int unsigned i = 0; i < 8; i++) begin
            for (int unsigned d = 0; d < 3; d++) begin
                if (sh[8+4*d +: 4] >= 4'd5)
                    sh[8+4*d +: 4] = sh[8+4*d +: 4] + 4'd3;
            end
            sh = sh << 1;
        end
        return sh[19:8];
    endfunction

    function automatic logic [7*NUM_DIGITS-1:0] render(input logic [7:0] bin,
                                                       input logic [2:0] idx);
        logic [11:0]             bcd;
        logic [7*NUM_DIGITS-1:0] segs;
        segs         = '1;
        bcd          = to_bcd(bin);
        segs[6:0]    = seg_encode(bcd[3:0]);
        segs[13:7]   = seg_encode(bcd[7:4]);
        segs[20:14]  = seg_encode(bcd[11:8]);
        segs[27:21]  = seg_encode({1'b0, idx});
        return segs;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value_q <= 8'hff;
            hex     <= render(8'hff, 3'd0);
        end else begin
            if (load)
                value_q <= value;
            hex <= render(load ? value : value_q, index);
        end
    end

endmodule

// File: rtl/aes_selftest_seq.sv
// Known-answer self-test sequencer: runs encrypt/decrypt vectors for each key
// size through an external AES engine and reports per-test pass bits.
module aes_selftest_seq
    import aes_pkg::*;
#(
    parameter int NUM_MODES  = 3,
    parameter int NUM_DIGITS = 6,
    parameter int TIMEOUT    = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    aes_selftest_seq_if.master      core,
    output logic                    busy,
    output logic                    done,
    output logic [2*NUM_MODES-1:0]  pass_mask,
    output logic                    all_pass,
    output logic                    timeout_flag,
    output logic [7*NUM_DIGITS-1:0] hex
);

    localparam int unsigned NUM_TESTS = 2 * NUM_MODES;
    localparam int          CNT_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [2:0]  LAST_T    = 3'(NUM_TESTS - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_e             state_q, state_d;
    logic [2:0]         t_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [127:0]       result_q;
    logic [127:0]       expected;
    logic               got_q;
    logic               last_test;
    logic               expired;

    assign last_test = (t_q == LAST_T);
    // Expiry is the TIMEOUT-th WAIT cycle; a core_done in that same cycle wins.
    assign expired   = (cnt_q == CNT_LAST);

    assign core.core_start   = (state_q == ISSUE);
    assign core.core_key_sel = key_sel_e'(t_q[2:1]);
    assign core.core_decrypt = t_q[0];
    assign core.core_block   = t_q[0] ? cipher_for(t_q[2:1]) : PLAINTEXT;
    assign expected          = t_q[0] ? PLAINTEXT : cipher_for(t_q[2:1]);

    assign busy     = (state_q == ISSUE) || (state_q == WAIT) || (state_q == CHECK);
    assign done     = (state_q == DONE);
    assign all_pass = done && (&pass_mask);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: if (start) state_d = ISSUE;
            ISSUE:      state_d = WAIT;
            WAIT:       if (core.core_done || expired) state_d = CHECK;
            CHECK:      state_d = last_test ? DONE : ISSUE;
            default:    state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            t_q          <= '0;
            cnt_q        <= '0;
            result_q     <= '0;
            got_q        <= 1'b0;
            pass_mask    <= '0;
            timeout_flag <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        t_q          <= '0;
                        pass_mask    <= '0;
                        timeout_flag <= 1'b0;
                    end
                end
                ISSUE: begin
                    cnt_q <= '0;
                    got_q <= 1'b0;
                end
                WAIT: begin
                    if (core.core_done) begin
                        result_q <= core.core_result;
                        got_q    <= 1'b1;
                    end else if (expired) begin
                        timeout_flag <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                CHECK: begin
                    for (int unsigned i = 0; i < NUM_TESTS; i++) begin
                        if (t_q == 3'(i) && got_q && result_q == expected)
                            pass_mask[i] <= 1'b1;
                    end
                    if (!last_test)
                        t_q <= t_q + 3'd1;
                end
                default: ;
            endcase
        end
    end

    aes_seg_display #(
        .NUM_DIGITS(NUM_DIGITS)
    ) u_display (
        .clk   (clk),
        .reset (reset),
        .load  (state_q == CHECK),
        .value (result_q[7:0]),
        .index (t_q),
        .hex   (hex)
    );

endmodule

// File: tb/tb_aes_selftest_seq.sv
// Self-checking bench: behavioural AES engine with configurable latency/faults,
// table-driven runs, randomized runs against a run-level model, corner sequences.
module tb_aes_selftest_seq;

    localparam int TIMEOUT = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, start, start_b;
    logic        busy, done, all_pass, timeout_flag;
    logic [5:0]  pass_mask;
    logic [41:0] hex;
    logic        busy_b, done_b, all_pass_b, tmo_b;
    logic [1:0]  pass_b;
    logic [27:0] hex_b;

    aes_selftest_seq_if bus ();
    aes_selftest_seq_if bus_b ();

    aes_selftest_seq #(.NUM_MODES(3), .NUM_DIGITS(6), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .start(start), .core(bus),
        .busy(busy), .done(done), .pass_mask(pass_mask), .all_pass(all_pass),
        .timeout_flag(timeout_flag), .hex(hex)
    );

    aes_selftest_seq #(.NUM_MODES(1), .NUM_DIGITS(4), .TIMEOUT(TIMEOUT)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .core(bus_b),
        .busy(busy_b), .done(done_b), .pass_mask(pass_b), .all_pass(all_pass_b),
        .timeout_flag(tmo_b), .hex(hex_b)
    );

    localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;
    logic [127:0] ct_ref [3] = '{128'h69c4e0d86a7b0430d8cdb78070b4c55a,
                                 128'hdda97ca4864cdfe06eaf70a0ec0d7191,
                                 128'h8ea2b7ca516745bfeafc49904b496089};
    logic [6:0] seg_ref [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                 7'b0000000, 7'b0010000};

    int checks = 0;
    int failures = 0;

    // Engine behaviour per test index: fault 0 = correct, 1 = flip one bit, 2 = silent.
    int lat_cfg [6];
    int fault_cfg [6];
    int flip_cfg [6];
    int starts_seen = 0;
    int starts_b = 0;
    bit mid_reset = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] engine_answer(input int ks, input logic dec,
                                                   input logic [127:0] blk);
        if (ks > 2) return ~blk;
        if (!dec && blk == PT) return ct_ref[ks];
        if (dec && blk == ct_ref[ks]) return PT;
        return ~blk;
    endfunction

    function automatic logic [55:0] exp_hex(input int value, input int idx);
        logic [55:0] h;
        h        = '1;
        h[6:0]   = seg_ref[value % 10];
        h[13:7]  = seg_ref[(value / 10) % 10];
        h[20:14] = seg_ref[value / 100];
        h[27:21] = seg_ref[idx];
        return h;
    endfunction

    // Run-level reference: which tests pass, whether any timed out, how many
    // cycles from the start pulse until done, and the last result byte shown.
    function automatic void model(output logic [5:0] m, output logic tmo,
                                  output int cyc, output int last_val);
        logic [127:0] o;
        m = '0; tmo = 1'b0; cyc = 1; last_val = -1;
        for (int t = 0; t < 6; t++) begin
            cyc += 2 + ((fault_cfg[t] == 2) ? TIMEOUT : lat_cfg[t]);
            if (fault_cfg[t] == 2) tmo = 1'b1;
            else if (fault_cfg[t] == 0) m[t] = 1'b1;
        end
        if (fault_cfg[5] != 2) begin
            o = PT;
            if (fault_cfg[5] == 1) o[flip_cfg[5]] = ~o[flip_cfg[5]];
            last_val = int'(o[7:0]);
        end
    endfunction

    initial begin : engine_a
        int k;
        logic [1:0] ks;
        logic dec;
        logic [127:0] blk, res, exp_blk;
        bus.core_done = 1'b0;
        bus.core_result = '0;
        forever begin
            @(negedge clk);
            if (bus.core_start === 1'b1) begin
                k = starts_seen % 6;
                starts_seen++;
                ks = bus.core_key_sel;
                dec = bus.core_decrypt;
                blk = bus.core_block;
                exp_blk = (k % 2 == 1) ? ct_ref[k / 2] : PT;
                check("key_sel", ks, k / 2);
                check("decrypt", dec, k % 2);
                check("block", blk, exp_blk);
                res = engine_answer(int'(ks), dec, blk);
                if (fault_cfg[k] == 1) res[flip_cfg[k]] = ~res[flip_cfg[k]];
                if (fault_cfg[k] != 2) begin
                    repeat (lat_cfg[k]) @(negedge clk);
                    if (!mid_reset) begin
                        check("stable key_sel", bus.core_key_sel, ks);
                        check("stable block", bus.core_block, blk);
                    end
                    bus.core_result = res;
                    bus.core_done = 1'b1;
                    @(negedge clk);
                    bus.core_done = 1'b0;
                    bus.core_result = ~res;
                end
            end
        end
    end

    initial begin : engine_b
        bus_b.core_done = 1'b0;
        bus_b.core_result = '0;
        forever begin
            @(negedge clk);
            if (bus_b.core_start === 1'b1) begin
                starts_b++;
                bus_b.core_result = engine_answer(int'(bus_b.core_key_sel),
                                                  bus_b.core_decrypt, bus_b.core_block);
                repeat (2) @(negedge clk);
                bus_b.core_done = 1'b1;
                @(negedge clk);
                bus_b.core_done = 1'b0;
            end
        end
    end

    task automatic set_cfg(input int base_lat, input int sp_t, input int sp_fault,
                           input int sp_lat, input int sp_bit);
        for (int t = 0; t < 6; t++) begin
            lat_cfg[t] = base_lat; fault_cfg[t] = 0; flip_cfg[t] = 0;
        end
        if (sp_t >= 0) begin
            lat_cfg[sp_t] = sp_lat; fault_cfg[sp_t] = sp_fault; flip_cfg[sp_t] = sp_bit;
        end
    endtask

    task automatic run_and_check(input string tag, input bit inject, input logic [5:0] em,
                                 input logic etmo, input int edisp);
        logic [5:0] mm;
        logic mt;
        int ecyc, lv, cyc;
        logic [55:0] eh;
        model(mm, mt, ecyc, lv);
        starts_seen = 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0; cyc = 1;
        check({tag, " core_start latency"}, bus.core_start, 1);
        while (done !== 1'b1 && cyc < ecyc + 20) begin
            start = (inject && busy === 1'b1 && $urandom_range(0, 5) == 0);
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check({tag, " run length"}, cyc, ecyc);
        check({tag, " done"}, done, 1);
        check({tag, " busy"}, busy, 0);
        check({tag, " pass_mask"}, pass_mask, em);
        check({tag, " timeout_flag"}, timeout_flag, etmo);
        check({tag, " all_pass"}, all_pass, em == 6'h3f);
        check({tag, " core_start count"}, starts_seen, 6);
        if (edisp >= 0) begin
            eh = exp_hex(edisp, 5);
            check({tag, " hex"}, hex, eh[41:0]);
        end
        repeat (3) @(negedge clk);
        check({tag, " done held"}, done, 1);
        check({tag, " pass_mask held"}, pass_mask, em);
    endtask

    typedef struct {
        int base_lat;
        int sp_t;
        int sp_fault;
        int sp_lat;
        int sp_bit;
        logic [5:0] mask;
        logic tmo;
        int disp;
    } vec_t;

    vec_t vecs [7];

    initial begin : main
        logic [55:0] eh;
        logic [5:0] mm;
        logic mt;
        int ecyc, lv, n;

        vecs[0] = '{3, -1, 0, 3, 0, 6'b111111, 1'b0, 255};
        vecs[1] = '{3, 3, 1, 3, 0, 6'b110111, 1'b0, 255};
        vecs[2] = '{3, 2, 2, 3, 0, 6'b111011, 1'b1, 255};
        vecs[3] = '{5, 0, 0, 64, 0, 6'b111111, 1'b0, 255};
        vecs[4] = '{1, 5, 1, 1, 3, 6'b011111, 1'b0, 247};
        vecs[5] = '{64, 5, 2, 64, 0, 6'b011111, 1'b1, -1};
        vecs[6] = '{2, 1, 1, 2, 127, 6'b111101, 1'b0, 255};

        set_cfg(3, -1, 0, 3, 0);
        reset = 1'b1; start = 1'b0; start_b = 1'b0;
        repeat (3) @(negedge clk);
        eh = exp_hex(255, 0);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset pass_mask", pass_mask, 0);
        check("reset timeout_flag", timeout_flag, 0);
        check("reset core_start", bus.core_start, 0);
        check("reset hex", hex, eh[41:0]);
        reset = 1'b0;
        @(negedge clk);
        check("idle all_pass", all_pass, 0);
        check("idle hex", hex, eh[41:0]);

        // Display after the first CHECK shows byte 5a of the 128-bit ciphertext.
        starts_seen = 0;
        start = 1'b1; @(negedge clk); start = 1'b0;
        n = 0;
        while (bus.core_done !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        check("first core_done seen", n < 20, 1);
        repeat (2) @(negedge clk);
        eh = exp_hex(90, 0);
        check("hex after test 0", hex[20:0], eh[20:0]);
        check("hex blank digits", hex[41:28], eh[41:28]);
        n = 0;
        while (done !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        check("first run all_pass", all_pass, 1);

        for (int i = 0; i < 7; i++) begin
            set_cfg(vecs[i].base_lat, vecs[i].sp_t, vecs[i].sp_fault,
                    vecs[i].sp_lat, vecs[i].sp_bit);
            run_and_check($sformatf("vec%0d", i), i % 2 == 1, vecs[i].mask,
                          vecs[i].tmo, vecs[i].disp);
        end

        // Reset during WAIT of test 3; the engine's late core_done must be ignored.
        set_cfg(10, -1, 0, 10, 0);
        starts_seen = 0;
        start = 1'b1; @(negedge clk); start = 1'b0;
        n = 0;
        while (starts_seen < 4 && n < 200) begin @(negedge clk); n++; end
        check("reached test 3", starts_seen, 4);
        @(negedge clk);
        mid_reset = 1;
        reset = 1'b1;
        #1;
        eh = exp_hex(255, 0);
        check("async reset busy", busy, 0);
        check("async reset core_start", bus.core_start, 0);
        check("async reset pass_mask", pass_mask, 0);
        check("async reset hex", hex, eh[41:0]);
        @(negedge clk);
        reset = 1'b0;
        repeat (15) @(negedge clk);
        mid_reset = 0;
        check("late done ignored busy", busy, 0);
        check("late done ignored done", done, 0);
        check("late done ignored pass_mask", pass_mask, 0);
        set_cfg(3, -1, 0, 3, 0);
        run_and_check("restart", 1, 6'b111111, 1'b0, 255);

        for (int r = 0; r < 6; r++) begin
            for (int t = 0; t < 6; t++) begin
                n = $urandom_range(0, 9);
                fault_cfg[t] = (n < 7) ? 0 : (n < 9) ? 1 : 2;
                flip_cfg[t] = $urandom_range(0, 127);
                lat_cfg[t] = ($urandom_range(0, 4) == 0) ? TIMEOUT : $urandom_range(1, TIMEOUT);
            end
            model(mm, mt, ecyc, lv);
            run_and_check($sformatf("rand%0d", r), 1, mm, mt, lv);
        end

        // Reduced configuration: one key size, four digits.
        start_b = 1'b1; @(negedge clk); start_b = 1'b0;
        n = 0;
        while (done_b !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        eh = exp_hex(255, 1);
        check("small done", done_b, 1);
        check("small pass_mask", pass_b, 2'b11);
        check("small all_pass", all_pass_b, 1);
        check("small timeout_flag", tmo_b, 0);
        check("small core_start count", starts_b, 2);
        check("small hex", hex_b, eh[27:0]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
